// File: rtl/imem_responder_pkg.sv
// ---------------------------------------------------------------------------
// imem_responder_pkg
//   Definitions shared by the instruction-memory responder and by other
//   pipeline blocks that have to recognise its idle word or its state.
//   - NOP_WORD_DEF : default word returned when no instruction is available
//                    (RV32I "addi x0, x0, 0").
//   - imem_state_e : SERVE / LOAD / COMMIT state encoding.
// ---------------------------------------------------------------------------
package imem_responder_pkg;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Program-load controller for imem_responder. Assembles a byte stream
//   (little-endian within each word) into 32-bit words and issues one
//   registered write per completed word. Owns the SERVE/LOAD/COMMIT FSM.
//
//   Ports
//     clk, rst        : clock, synchronous active-low reset
//     ld_start_i      : pulse, (re)start a load at word 0
//     ld_valid_i      : loader byte present
//     ld_data_i[7:0]  : loader byte
//     ld_last_i       : qualifies the final byte of the image
//     ld_ready_o      : byte accepted when ld_valid_i & ld_ready_o
//     ld_busy_o       : load in progress (LOAD or COMMIT)
//     ld_overflow_o   : sticky, image exceeded DEPTH_WORDS
//     state_o         : current FSM state (fetch gating and debug)
//     wr_en_o         : memory write strobe
//     wr_addr_o       : memory word address
//     wr_data_o       : memory write data
//
//   Handshake: a byte is transferred on every rising edge where
//   ld_valid_i and ld_ready_o are both 1; ld_ready_o does not depend on
//   ld_valid_i, and the source may hold ld_valid_i high for back-to-back
//   bytes. ld_start_i has priority over a byte presented in the same cycle,
//   which is then dropped as part of the restart.
// ---------------------------------------------------------------------------
module imem_loader
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start_i,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_data_i,
  input  logic          ld_last_i,
  output logic          ld_ready_o,
  output logic          ld_busy_o,
  output logic          ld_overflow_o,
  output imem_state_e   state_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [31:0]   wr_data_o
);

  imem_state_e   state_q;
  logic [1:0]    byte_ptr_q;
  logic [AW:0]   word_ptr_q;   // one extra bit so it can hold DEPTH_WORDS
  logic [31:0]   asm_q;
  logic          ld_ready_q;
  logic          ld_busy_q;
  logic          ld_overflow_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [31:0]   wr_data_q;

  logic          accept;
  logic          word_done;
  logic          mem_full;
  logic [31:0]   asm_d;

  assign accept    = (state_q == ST_LOAD) && ld_valid_i && ld_ready_q;
  // A word leaves the assembler when lane 3 fills or the image ends early.
  assign word_done = (byte_ptr_q == 2'd3) || ld_last_i;
  assign mem_full  = (word_ptr_q == (AW+1)'(DEPTH_WORDS));

  // Merge the incoming byte into its lane. Lanes not yet filled stay zero
  // because the assembler is cleared after every emitted word.
  always_comb begin
    asm_d = asm_q;
    case (byte_ptr_q)
      2'd0:    asm_d[7:0]   = ld_data_i;
      2'd1:    asm_d[15:8]  = ld_data_i;
      2'd2:    asm_d[23:16] = ld_data_i;
      default: asm_d[31:24] = ld_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_SERVE;
      byte_ptr_q    <= 2'd0;
      word_ptr_q    <= '0;
      asm_q         <= 32'd0;
      ld_ready_q    <= 1'b0;
      ld_busy_q     <= 1'b0;
      ld_overflow_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 32'd0;
    end else begin
      wr_en_q <= 1'b0;
      if (ld_start_i) begin
        state_q       <= ST_LOAD;
        byte_ptr_q    <= 2'd0;
        word_ptr_q    <= '0;
        asm_q         <= 32'd0;
        ld_overflow_q <= 1'b0;
        ld_ready_q    <= 1'b1;
        ld_busy_q     <= 1'b1;
      end else begin
        case (state_q)
          ST_SERVE: begin
            ld_ready_q <= 1'b0;
            ld_busy_q  <= 1'b0;
          end
          ST_LOAD: begin
            if (accept) begin
              byte_ptr_q <= byte_ptr_q + 2'd1;
              if (word_done) begin
                asm_q <= 32'd0;
                if (mem_full) begin
                  // Image is larger than the array: drop the word, keep
                  // consuming bytes until ld_last.
                  ld_overflow_q <= 1'b1;
                end else begin
                  wr_en_q    <= 1'b1;
                  wr_addr_q  <= word_ptr_q[AW-1:0];
                  wr_data_q  <= asm_d;
                  word_ptr_q <= word_ptr_q + 1'b1;
                end
              end else begin
                asm_q <= asm_d;
              end
              if (ld_last_i) begin
                // The final write is issued during COMMIT, so it lands on
                // the edge that returns to SERVE, before any fetch read.
                state_q    <= ST_COMMIT;
                byte_ptr_q <= 2'd0;
                ld_ready_q <= 1'b0;
              end
            end
          end
          ST_COMMIT: begin
            state_q    <= ST_SERVE;
            ld_ready_q <= 1'b0;
            ld_busy_q  <= 1'b0;
          end
          default: begin
            state_q    <= ST_SERVE;
            ld_ready_q <= 1'b0;
            ld_busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ld_ready_o    = ld_ready_q;
  assign ld_busy_o     = ld_busy_q;
  assign ld_overflow_o = ld_overflow_q;
  assign state_o       = state_q;
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;

endmodule

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Instruction memory with a 1-cycle fetch port and a byte-serial program
//   loader. Fetches are served only in SERVE; while a load is in progress
//   every fetch returns NOP_WORD with instr_valid=0, so the write port and
//   the read port never touch the array in the same cycle.
//
//   Ports
//     clk, rst          : clock, synchronous active-low reset
//     cs_i_n            : fetch chip select, active-low
//     i_addr[31:0]      : fetch byte address
//     instr_read[31:0]  : fetched word (registered, one cycle after request)
//     instr_valid       : instr_read answers last cycle's request
//     addr_err          : last request was misaligned or out of range
//     ld_start          : pulse, begin program load at word 0
//     ld_valid/ld_data/ld_last/ld_ready : loader byte stream
//     ld_busy           : load in progress, fetch suspended
//     ld_overflow       : sticky, image exceeded DEPTH_WORDS
//     dbg_state_o       : current loader FSM state
// ---------------------------------------------------------------------------
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_i_n,
  input  logic [31:0] i_addr,
  output logic [31:0] instr_read,
  output logic        instr_valid,
  output logic        addr_err,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_overflow,
  output imem_state_e dbg_state_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]   mem [DEPTH_WORDS];

  imem_state_e   state;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  logic [31:0]   word_idx;
  logic          misaligned;
  logic          out_of_range;

  logic [31:0]   instr_read_q;
  logic          instr_valid_q;
  logic          addr_err_q;

  imem_loader #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_loader (
    .clk           (clk),
    .rst           (rst),
    .ld_start_i    (ld_start),
    .ld_valid_i    (ld_valid),
    .ld_data_i     (ld_data),
    .ld_last_i     (ld_last),
    .ld_ready_o    (ld_ready),
    .ld_busy_o     (ld_busy),
    .ld_overflow_o (ld_overflow),
    .state_o       (state),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data)
  );

  // Storage has no reset: a reset must leave the loaded program intact.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    word_idx     = {2'b00, i_addr[31:2]};
    misaligned   = (i_addr[1:0] != 2'b00);
    out_of_range = (word_idx >= 32'(DEPTH_WORDS));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_read_q  <= NOP_WORD;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else if (!cs_i_n && (state == ST_SERVE)) begin
      instr_valid_q <= 1'b1;
      if (misaligned || out_of_range) begin
        instr_read_q <= NOP_WORD;
        addr_err_q   <= 1'b1;
      end else begin
        instr_read_q <= mem[word_idx[AW-1:0]];
        addr_err_q   <= 1'b0;
      end
    end else begin
      // No request, or a request while a load owns the array.
      instr_read_q  <= NOP_WORD;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end
  end

  assign instr_read  = instr_read_q;
  assign instr_valid = instr_valid_q;
  assign addr_err    = addr_err_q;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//   Directed bench for imem_responder. u_big uses the default 1024-word
//   depth; u_small uses DEPTH_WORDS=4 to reach the overflow boundary.
// ---------------------------------------------------------------------------
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // big instance
  logic        m_cs_n = 1'b1;
  logic [31:0] m_addr = 32'd0;
  logic        m_ld_start = 1'b0, m_ld_valid = 1'b0, m_ld_last = 1'b0;
  logic [7:0]  m_ld_data = 8'd0;
  logic [31:0] m_instr;
  logic        m_valid, m_err, m_ready, m_busy, m_ovf;
  imem_state_e m_state;

  // small instance
  logic        s_cs_n = 1'b1;
  logic [31:0] s_addr = 32'd0;
  logic        s_ld_start = 1'b0, s_ld_valid = 1'b0, s_ld_last = 1'b0;
  logic [7:0]  s_ld_data = 8'd0;
  logic [31:0] s_instr;
  logic        s_valid, s_err, s_ready, s_busy, s_ovf;
  imem_state_e s_state;

  imem_responder u_big (
    .clk(clk), .rst(rst), .cs_i_n(m_cs_n), .i_addr(m_addr),
    .instr_read(m_instr), .instr_valid(m_valid), .addr_err(m_err),
    .ld_start(m_ld_start), .ld_valid(m_ld_valid), .ld_data(m_ld_data),
    .ld_last(m_ld_last), .ld_ready(m_ready), .ld_busy(m_busy),
    .ld_overflow(m_ovf), .dbg_state_o(m_state)
  );

  imem_responder #(.DEPTH_WORDS(4)) u_small (
    .clk(clk), .rst(rst), .cs_i_n(s_cs_n), .i_addr(s_addr),
    .instr_read(s_instr), .instr_valid(s_valid), .addr_err(s_err),
    .ld_start(s_ld_start), .ld_valid(s_ld_valid), .ld_data(s_ld_data),
    .ld_last(s_ld_last), .ld_ready(s_ready), .ld_busy(s_busy),
    .ld_overflow(s_ovf), .dbg_state_o(s_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] img [32];

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_byte(input bit sel, input logic v, input logic [7:0] d, input logic l);
    if (sel) begin s_ld_valid = v; s_ld_data = d; s_ld_last = l; end
    else     begin m_ld_valid = v; m_ld_data = d; m_ld_last = l; end
  endtask

  // Start pulse, then img[0..n-1] back to back; returns after the edge
  // that accepted the final byte.
  task automatic load(input bit sel, input int n, input bit with_last);
    if (sel) s_ld_start = 1'b1; else m_ld_start = 1'b1;
    tick();
    if (sel) s_ld_start = 1'b0; else m_ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_byte(sel, 1'b1, img[i], with_last && (i == n - 1));
      tick();
    end
    drive_byte(sel, 1'b0, 8'h00, 1'b0);
  endtask

  // One-cycle fetch request; outputs answer it on return.
  task automatic fetch(input bit sel, input logic [31:0] a);
    if (sel) begin s_cs_n = 1'b0; s_addr = a; end
    else     begin m_cs_n = 1'b0; m_addr = a; end
    tick();
    if (sel) s_cs_n = 1'b1; else m_cs_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    rst = 1'b0;
    tick(); tick();
    chk("rst_instr",  m_instr, NOP);
    chk("rst_valid",  32'(m_valid), 32'd0);
    chk("rst_err",    32'(m_err), 32'd0);
    chk("rst_ready",  32'(m_ready), 32'd0);
    chk("rst_busy",   32'(m_busy), 32'd0);
    chk("rst_ovf",    32'(m_ovf), 32'd0);
    chk("rst_state",  32'(m_state), 32'(ST_SERVE));
    chk("rst_s_ovf",  32'(s_ovf), 32'd0);
    rst = 1'b1;
    tick();

    // loader bytes outside LOAD are ignored
    drive_byte(1'b0, 1'b1, 8'hEE, 1'b1);
    tick();
    chk("idle_ready", 32'(m_ready), 32'd0);
    chk("idle_busy",  32'(m_busy), 32'd0);
    drive_byte(1'b0, 1'b0, 8'h00, 1'b0);

    // two-word image, last on 8th byte
    img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h50; img[3] = 8'h00;
    img[4] = 8'h93; img[5] = 8'h05; img[6] = 8'hA0; img[7] = 8'h00;
    load(1'b0, 8, 1'b1);
    chk("commit_state", 32'(m_state), 32'(ST_COMMIT));
    chk("commit_busy",  32'(m_busy), 32'd1);
    chk("commit_ready", 32'(m_ready), 32'd0);
    tick();
    chk("serve_busy",   32'(m_busy), 32'd0);
    chk("serve_state",  32'(m_state), 32'(ST_SERVE));
    fetch(1'b0, 32'h0);
    chk("f0_instr", m_instr, 32'h0050_0513);
    chk("f0_valid", 32'(m_valid), 32'd1);
    chk("f0_err",   32'(m_err), 32'd0);
    fetch(1'b0, 32'h4);
    chk("f4_instr", m_instr, 32'h00A0_0593);
    chk("f4_valid", 32'(m_valid), 32'd1);
    chk("f4_err",   32'(m_err), 32'd0);
    tick();
    chk("nocs_instr", m_instr, NOP);
    chk("nocs_valid", 32'(m_valid), 32'd0);

    // misaligned and out-of-range fetches
    fetch(1'b0, 32'h6);
    chk("mis_instr", m_instr, NOP);
    chk("mis_valid", 32'(m_valid), 32'd1);
    chk("mis_err",   32'(m_err), 32'd1);
    fetch(1'b0, 32'h1000);
    chk("oor_instr", m_instr, NOP);
    chk("oor_valid", 32'(m_valid), 32'd1);
    chk("oor_err",   32'(m_err), 32'd1);
    fetch(1'b0, 32'hFFC);
    chk("top_valid", 32'(m_valid), 32'd1);
    chk("top_err",   32'(m_err), 32'd0);

    // partial word; fetches during LOAD and COMMIT are refused
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
    m_cs_n = 1'b0; m_addr = 32'h0;
    load(1'b0, 3, 1'b1);
    chk("ldf_instr", m_instr, NOP);
    chk("ldf_valid", 32'(m_valid), 32'd0);
    chk("ldf_err",   32'(m_err), 32'd0);
    tick();
    chk("cmf_valid", 32'(m_valid), 32'd0);
    chk("cmf_instr", m_instr, NOP);
    m_cs_n = 1'b1;
    fetch(1'b0, 32'h0);
    chk("part_instr", m_instr, 32'h00CC_BBAA);
    fetch(1'b0, 32'h4);
    chk("part_keep",  m_instr, 32'h00A0_0593);

    // reset after 6 bytes of a load
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33;
    img[3] = 8'h44; img[4] = 8'h55; img[5] = 8'h66;
    load(1'b0, 6, 1'b0);
    chk("mid_busy", 32'(m_busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mr_instr", m_instr, NOP);
    chk("mr_valid", 32'(m_valid), 32'd0);
    chk("mr_err",   32'(m_err), 32'd0);
    chk("mr_ready", 32'(m_ready), 32'd0);
    chk("mr_busy",  32'(m_busy), 32'd0);
    chk("mr_ovf",   32'(m_ovf), 32'd0);
    chk("mr_state", 32'(m_state), 32'(ST_SERVE));
    fetch(1'b0, 32'h0);
    chk("mr_w0", m_instr, 32'h4433_2211);
    fetch(1'b0, 32'h4);
    chk("mr_w1", m_instr, 32'h00A0_0593);

    // overflow on a 4-word array with a 20-byte image
    for (int i = 0; i < 20; i++) img[i] = 8'(i);
    load(1'b1, 20, 1'b1);
    chk("ov_commit_busy", 32'(s_busy), 32'd1);
    tick();
    chk("ov_flag", 32'(s_ovf), 32'd1);
    fetch(1'b1, 32'h0);
    chk("ov_w0", s_instr, 32'h0302_0100);
    fetch(1'b1, 32'h4);
    chk("ov_w1", s_instr, 32'h0706_0504);
    fetch(1'b1, 32'h8);
    chk("ov_w2", s_instr, 32'h0B0A_0908);
    fetch(1'b1, 32'hC);
    chk("ov_w3", s_instr, 32'h0F0E_0D0C);
    fetch(1'b1, 32'h10);
    chk("ov_oor_err",   32'(s_err), 32'd1);
    chk("ov_oor_instr", s_instr, NOP);
    chk("ov_sticky", 32'(s_ovf), 32'd1);
    img[0] = 8'h77;
    load(1'b1, 1, 1'b1);
    chk("ov_cleared", 32'(s_ovf), 32'd0);
    tick();
    fetch(1'b1, 32'h0);
    chk("ov_reload", s_instr, 32'h0000_0077);
    chk("ov_reload_err", 32'(s_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: instruction storage depth in 32-bit words; power of two.
REQ-002 Parameter NOP_WORD, default 32'h0000_0013: word returned whenever no valid instruction is available.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 cs_i_n  input  1  fetch chip select, active-low; 0 = read request this cycle.
REQ-006 i_addr  input  32  fetch byte address.
REQ-007 instr_read  output  32  fetched instruction word.
REQ-008 instr_valid  output  1  instr_read holds data for the request of the previous cycle.
REQ-009 addr_err  output  1  previous request was misaligned or out of range.
REQ-010 ld_start  input  1  pulse: begin program load at word 0.
REQ-011 ld_valid  input  1  loader byte present.
REQ-012 ld_data  input  8  loader byte, little-endian within each word.
REQ-013 ld_last  input  1  qualifies final byte of image.
REQ-014 ld_ready  output  1  loader byte accepted when ld_valid&ld_ready.
REQ-015 ld_busy  output  1  load in progress; fetch service suspended.
REQ-016 ld_overflow  output  1  sticky: image exceeded DEPTH_WORDS.

Function
REQ-017 States: SERVE (fetch reads), LOAD (accepting bytes), COMMIT (one-cycle final-word write); reset state SERVE.
REQ-018 SERVE->LOAD when ld_start=1; LOAD->COMMIT on accepted byte with ld_last=1; COMMIT->SERVE unconditionally; ld_start in LOAD or COMMIT restarts LOAD with pointers cleared.
REQ-019 Fetch latency exactly 1 cycle: request with cs_i_n=0 in cycle N produces instr_read/instr_valid/addr_err in cycle N+1.
REQ-020 In SERVE, cs_i_n=0, i_addr[1:0]=0, i_addr word index < DEPTH_WORDS: instr_read=mem[i_addr>>2], instr_valid=1, addr_err=0.
REQ-021 In SERVE, cs_i_n=0 with i_addr[1:0]!=0 or i_addr>>2 >= DEPTH_WORDS: instr_read=NOP_WORD, instr_valid=1, addr_err=1.
REQ-022 cs_i_n=1 in any state: next cycle instr_read=NOP_WORD, instr_valid=0, addr_err=0.
REQ-023 cs_i_n=0 while in LOAD or COMMIT: next cycle instr_read=NOP_WORD, instr_valid=0, addr_err=0.
REQ-024 ld_ready=1 only in LOAD; ld_busy=1 in LOAD and COMMIT.
REQ-025 Accepted bytes fill assembly register at lane byte_ptr (0..3); byte_ptr wraps 3->0; on lane-3 accept, word written to mem[word_ptr], word_ptr increments.
REQ-026 On ld_last accept, partial word (lanes not yet filled = 8'h00) written in COMMIT if byte_ptr!=0 after the accept; complete word written normally.
REQ-027 Write when word_ptr=DEPTH_WORDS: write suppressed, ld_overflow set; remaining bytes still accepted and discarded.
REQ-028 ld_overflow cleared only by reset or ld_start.
REQ-029 Write and read never target the same cycle: fetch reads blocked outside SERVE, so no bypass required.
REQ-030 ld_valid/ld_data/ld_last ignored outside LOAD.

Reset
REQ-031 On rst=0 at a clock edge: state=SERVE, instr_read=NOP_WORD, instr_valid=0, addr_err=0, ld_ready=0, ld_busy=0, ld_overflow=0, byte_ptr=0, word_ptr=0, assembly register=0.
REQ-032 Memory contents unaffected by reset; reset mid-LOAD abandons the partial word without writing it.

Structure
REQ-033 Shared package holds NOP_WORD constant and the SERVE/LOAD/COMMIT state encoding, reused by other pipeline blocks.
REQ-034 Byte assembler and pointer logic in one sub-module imem_loader; storage array and fetch read port in imem_responder.

Verification
REQ-035 Load bytes 13,05,50,00, 93,05,A0,00 with ld_last on 8th -> mem[0]=0x00500513, mem[1]=0x00A00593, ld_busy falls one cycle after COMMIT.
REQ-036 After load, cs_i_n=0, i_addr=0x4 in cycle N -> cycle N+1 instr_read=0x00A00593, instr_valid=1, addr_err=0.
REQ-037 cs_i_n=0, i_addr=0x6, then i_addr=0x1000 (DEPTH 1024) -> both return 0x00000013, instr_valid=1, addr_err=1.
REQ-038 Load 3 bytes AA,BB,CC with ld_last on third -> mem[0]=0x00CCBBAA; fetch during load returns instr_valid=0, NOP_WORD.
REQ-039 DEPTH_WORDS=4, load 20 bytes -> mem[0..3] written, ld_overflow=1, remains 1 until next ld_start.
REQ-040 Assert rst=0 after 6 bytes of load -> next cycle all outputs at reset values, mem[0] holds first 4 bytes, mem[1] unchanged.
